rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width of each requester path and of data_o.
REQ-002 The block SHALL have port clock_i, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_i, input, 1, the asynchronous active-high reset.
REQ-004 The block SHALL have port req_i, input, 4, per-requester request; bit n high means requester n holds valid data on datan_i.
REQ-005 The block SHALL have ports data0_i, data1_i, data2_i and data3_i, input, WIDTH each, the requester data held stable while the matching req_i bit is high.
REQ-006 The block SHALL have port gnt_o, output, 4, one-hot grant held for the whole transaction.
REQ-007 The block SHALL have port done_o, output, 4, one-hot completion equal to gnt_o AND ack_i, combinational.
REQ-008 The block SHALL have port select_o, output, 2, the index of the granted requester, which is also the shared mux select.
REQ-009 The block SHALL have port valid_o, output, 1, meaning data_o carries a granted transfer.
REQ-010 The block SHALL have port data_o, output, WIDTH, the data of the granted requester.
REQ-011 The block SHALL have port ack_i, input, 1, the downstream acceptance of data_o, sampled only while valid_o is high.

Function
REQ-012 The FSM SHALL have two states: IDLE and BUSY.
REQ-013 In IDLE with req_i nonzero, the block SHALL pick the winner in priority order last+1, last+2, last+3, last+4 (mod 4), then register select_o, gnt_o and valid_o=1, and enter BUSY at the next edge.
REQ-014 In IDLE with req_i equal to 0, the block SHALL stay in IDLE and hold gnt_o=0 and valid_o=0.
REQ-015 Latency from req_i rising in IDLE to valid_o high SHALL be exactly 1 clock.
REQ-016 In BUSY, gnt_o, select_o and valid_o SHALL stay constant until a cycle in which ack_i=1.
REQ-017 In BUSY with ack_i=1, done_o[select_o] SHALL be 1 in that same cycle, the block SHALL set last to select_o, clear gnt_o and valid_o, and return to IDLE at the edge.
REQ-018 A requester SHALL drop its req_i bit at the edge where it sees done_o; the arbiter relies on this, and the IDLE cycle after a grant then sees the updated req_i.
REQ-019 Minimum spacing between grants SHALL be 2 clocks (one BUSY cycle plus one IDLE cycle).
REQ-020 Changes to req_i during BUSY, including a withdrawal by the granted requester, SHALL NOT alter the grant; the transfer is completed on ack_i.
REQ-021 ack_i while valid_o=0 SHALL be ignored, and done_o SHALL stay 0.
REQ-022 When only requester last is requesting, it SHALL be re-granted, selected at position last+4.
REQ-023 data_o SHALL equal the data input indexed by select_o through combinational selection, with no added latency.
REQ-024 In IDLE, data_o SHALL be don't-care; the bench checks data_o only when valid_o=1.

Reset
REQ-025 While reset_i is asserted, the block SHALL hold state=IDLE, gnt_o=0, valid_o=0, select_o=0 and last=3, so that requester 0 has first priority.
REQ-026 Reset asserted mid-BUSY SHALL abort the transfer immediately and drive done_o=0; the requester's req_i stays high and is re-arbitrated after reset.
REQ-027 Reset deassertion SHALL take effect at the first clock_i rising edge after release, and the first grant SHALL be possible on that edge.

Structure
REQ-028 The IDLE/BUSY state encodings and the requester-count and index-width constants (4, 2) SHALL live in the shared definitions header used by the lib blocks.
REQ-029 The data path SHALL be one existing mux4to1 instance with parameter WIDTH, select driven by select_o and output driving data_o; arbitration and FSM logic stay in rr_arbiter4.

Verification
REQ-030 Bench data SHALL be data0_i=8'h45, data1_i=8'h1a, data2_i=8'h6d, data3_i=8'h30, with WIDTH=8 for all scenarios.
REQ-031 Scenario: reset, then req_i=4'b0100 -> one clock later gnt_o=4'b0100, select_o=2, valid_o=1, data_o=8'h6d; ack_i=1 -> done_o=4'b0100 in the same cycle, then valid_o=0.
REQ-032 Scenario: after reset, req_i=4'b1111 held, ack_i=1 every valid cycle -> grant order 0,1,2,3,0 with data_o=45,1a,6d,30,45 and one grant every 2 clocks.
REQ-033 Scenario: grant to 1, then req_i=4'b0010 only after completion -> 1 is re-granted (wrap-around), data_o=8'h1a.
REQ-034 Scenario: grant to 3, ack_i held 0 for 5 cycles while req_i changes to 4'b0001 -> gnt_o stays 4'b1000, data_o=8'h30, done_o=0 until ack_i.
REQ-035 Scenario: reset_i pulsed during BUSY for requester 2 -> gnt_o=0, valid_o=0 and done_o=0 at once; after release with req_i=4'b0100 still high, 2 is re-granted on the first clock edge.

Source files
------------

// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter: sizes,
// FSM encodings and the rotating-priority pick function.
package rr_arbiter4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Returns the first requester found in the order last+1 .. last+4 (mod 4).
  // Searching from lowest priority upward lets the last hit be the winner.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    pick = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = last + IDX_W'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4to1.sv
// Combinational 4-to-1 data selector used as the arbiter's shared data path.
module mux4to1 #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with an IDLE/BUSY grant FSM and
// a shared data mux driven by the registered grant index.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [3:0]       req_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [WIDTH-1:0] data3_i,
  input  logic             ack_i,
  output logic [3:0]       gnt_o,
  output logic [3:0]       done_o,
  output logic [1:0]       select_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [0:0]       state_o
);

  // Handshake: data_o is offered while valid_o=1; a transfer completes in a
  // cycle with valid_o=1 and ack_i=1. ack_i with valid_o=0 has no effect.

  logic [0:0]       state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] winner;
  logic             xfer;

  assign winner = rr_pick(req_i, last);
  assign xfer   = valid_o & ack_i;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= ST_IDLE;
      last     <= 2'd3;
      gnt_o    <= '0;
      select_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_i != '0) begin
            state    <= ST_BUSY;
            select_o <= winner;
            gnt_o    <= idx_to_onehot(winner);
            valid_o  <= 1'b1;
          end
        end
        ST_BUSY: begin
          // Grant is frozen until the downstream accepts; req_i is ignored.
          if (ack_i) begin
            state   <= ST_IDLE;
            last    <= select_o;
            gnt_o   <= '0;
            valid_o <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          gnt_o   <= '0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

  assign done_o  = gnt_o & {4{xfer}};
  assign state_o = state;

  mux4to1 #(.WIDTH(WIDTH)) u_data_mux (
    .sel (select_o),
    .in0 (data0_i),
    .in1 (data1_i),
    .in2 (data2_i),
    .in3 (data3_i),
    .out (data_o)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: fixed requester data, hand-computed grants.
module tb_rr_arbiter4;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic             ack;
  logic [3:0]       gnt;
  logic [3:0]       done;
  logic [1:0]       sel;
  logic             valid;
  logic [WIDTH-1:0] data;
  logic [0:0]       state;

  int checks;
  int failures;

  // Expected data per requester index
  logic [WIDTH-1:0] exp_data [4];

  rr_arbiter4 #(.WIDTH(WIDTH)) dut (
    .clock_i  (clk),
    .reset_i  (rst),
    .req_i    (req),
    .data0_i  (d0),
    .data1_i  (d1),
    .data2_i  (d2),
    .data3_i  (d3),
    .ack_i    (ack),
    .gnt_o    (gnt),
    .done_o   (done),
    .select_o (sel),
    .valid_o  (valid),
    .data_o   (data),
    .state_o  (state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish (actual=timeout required=finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_busy(input string tag, input int idx, input logic exp_ack);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    check({tag, " gnt"},   32'(gnt),   32'(oh));
    check({tag, " sel"},   32'(sel),   32'(idx));
    check({tag, " valid"}, 32'(valid), 32'd1);
    check({tag, " data"},  32'(data),  32'(exp_data[idx]));
    check({tag, " state"}, 32'(state), 32'd1);
    check({tag, " done"},  32'(done),  exp_ack ? 32'(oh) : 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " gnt"},   32'(gnt),   32'd0);
    check({tag, " valid"}, 32'(valid), 32'd0);
    check({tag, " done"},  32'(done),  32'd0);
    check({tag, " state"}, 32'(state), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int order [5];
    checks   = 0;
    failures = 0;
    exp_data[0] = 8'h45;
    exp_data[1] = 8'h1a;
    exp_data[2] = 8'h6d;
    exp_data[3] = 8'h30;
    d0 = 8'h45; d1 = 8'h1a; d2 = 8'h6d; d3 = 8'h30;
    rst = 1'b0; req = 4'b0000; ack = 1'b1;
    #1 rst = 1'b1;
    #2;
    // reset state, with ack high to show it is ignored
    check_idle("reset");
    check("reset sel", 32'(sel), 32'd0);
    ack = 1'b0;
    step();
    step();
    rst = 1'b0;

    // single request from 2, one-clock latency
    req = 4'b0100;
    #1 check("s1 latency valid", 32'(valid), 32'd0);
    step();
    check_busy("s1 grant", 2, 1'b0);
    ack = 1'b1;
    #1 check_busy("s1 ack", 2, 1'b1);
    step();
    req = 4'b0000;
    check_idle("s1 after");

    // last=2, requests 0 and 1: wrap-around picks 0
    req = 4'b0011;
    ack = 1'b0;
    step();
    check_busy("wrap grant", 0, 1'b0);
    ack = 1'b1;
    #1 check_busy("wrap ack", 0, 1'b1);
    step();
    req = 4'b0000;
    ack = 1'b0;
    step();

    // all requesting, ack always high: 0,1,2,3,0 every 2 clocks
    pulse_reset();
    req = 4'b1111;
    ack = 1'b1;
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      step();
      check_busy($sformatf("s2 grant%0d", i), order[i], 1'b1);
      step();
      check_idle($sformatf("s2 gap%0d", i));
    end
    req = 4'b0000;
    ack = 1'b0;
    step();

    // last=0: grant 1, then lone requester 1 is re-granted
    req = 4'b0010;
    ack = 1'b1;
    step();
    check_busy("s3 first", 1, 1'b1);
    step();
    check_idle("s3 gap");
    step();
    check_busy("s3 regrant", 1, 1'b1);
    step();
    req = 4'b0000;
    ack = 1'b0;
    step();

    // grant 3 held through 5 un-acked cycles while req changes
    req = 4'b1000;
    step();
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      check_busy($sformatf("s4 hold%0d", i), 3, 1'b0);
      step();
    end
    ack = 1'b1;
    #1 check_busy("s4 ack", 3, 1'b1);
    step();
    check_idle("s4 gap");
    step();
    check_busy("s4 next", 0, 1'b1);
    step();
    req = 4'b0000;
    ack = 1'b0;
    step();

    // reset during BUSY aborts, then 2 is re-granted on first edge
    pulse_reset();
    req = 4'b0100;
    step();
    check_busy("s5 grant", 2, 1'b0);
    #2;
    rst = 1'b1;
    ack = 1'b1;
    #1;
    check_idle("s5 abort");
    check("s5 abort sel", 32'(sel), 32'd0);
    step();
    rst = 1'b0;
    ack = 1'b0;
    step();
    check_busy("s5 regrant", 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
